// File: rtl/alu_writeback_buffer.sv
// alu_writeback_buffer
//
// Write-back stage behind the ALU. Each new ALU result is flagged by a
// one-edge ac_load strobe and is captured into a small FIFO. The FIFO is then
// drained to data memory through a valid/ready write port, at consecutive
// addresses starting at base_addr. One job covers `count` results. done
// pulses for one cycle after the last stored result has been accepted by
// memory.
//
// Optional feature (macro WB_ZERO_COUNT_EN):
//   Adds the zero_cnt output. zero_cnt counts the accepted pushes whose
//   alu_zflag was high. It saturates at all-ones and is cleared by an
//   accepted start. Without the macro, alu_zflag is not used.
//
// Ports:
//   clk        in   1       system clock; all state changes on the rising edge
//   rst        in   1       asynchronous, active-high reset
//   start      in   1       one-cycle job launch; honoured only in IDLE
//   base_addr  in   ADDR_W  first write address, latched on start
//   count      in   ADDR_W  number of results in the job, latched on start
//   alu_out    in   DATA_W  ALU result
//   ac_load    in   1       new-result strobe from the ALU
//   alu_zflag  in   1       ALU zero flag that goes with alu_out
//   mem_wr_en  out  1       memory write request (valid)
//   mem_addr   out  ADDR_W  memory write address
//   mem_wdata  out  DATA_W  memory write data (FIFO head)
//   mem_ready  in   1       memory accepts the write
//   busy       out  1       job in progress
//   done       out  1       one-cycle end-of-job pulse
//   fifo_full  out  1       FIFO holds DEPTH entries
//   overflow   out  1       sticky flag: a capture was dropped
//   zero_cnt   out  ADDR_W  zero-result counter (WB_ZERO_COUNT_EN only)
`timescale 1ns/1ps

module alu_writeback_buffer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] count,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              ac_load,
  input  logic              alu_zflag,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              fifo_full,
  output logic              overflow
`ifdef WB_ZERO_COUNT_EN
  ,
  output logic [ADDR_W-1:0] zero_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] fifo_q [DEPTH];
  logic [DATA_W-1:0] fifo_d [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] captured_q, captured_d;
  logic [ADDR_W-1:0] pushed_q, pushed_d;
  logic [ADDR_W-1:0] written_q, written_d;
  logic              overflow_q, overflow_d;

`ifdef WB_ZERO_COUNT_EN
  logic [ADDR_W-1:0] zero_cnt_q, zero_cnt_d;
`else
  logic unused_zflag;
  assign unused_zflag = alu_zflag;
`endif

  logic fifo_empty;
  logic fifo_is_full;
  logic in_run;
  logic start_ok;
  logic xfer;
  logic capture;
  logic push;
  logic drop;
  logic last_xfer;

  // Handshake and capture qualifiers. A push into a full FIFO is still
  // accepted when the head leaves in the same cycle, so occupancy never
  // exceeds DEPTH.
  always_comb begin
    fifo_empty   = (occ_q == '0);
    fifo_is_full = (occ_q == OCC_W'(DEPTH));
    in_run       = (state_q == ST_RUN);
    start_ok     = start && (state_q == ST_IDLE);
    xfer         = in_run && !fifo_empty && mem_ready;
    capture      = in_run && ac_load && (captured_q < count_q);
    push         = capture && (!fifo_is_full || xfer);
    drop         = capture && fifo_is_full && !xfer;
    // The job ends once every result has been captured and the transfer
    // in flight is the last stored one. Dropped results never reach the
    // FIFO, so the comparison is against accepted pushes.
    last_xfer    = xfer && (captured_q == count_q) &&
                   ((written_q + ADDR_W'(1)) == pushed_q);
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (count == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_xfer) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs. These depend only on registered state, so there is no
  // combinational path from mem_ready to mem_wr_en. The write data is
  // forced to zero while no request is pending.
  always_comb begin
    busy      = (state_q == ST_RUN);
    done      = (state_q == ST_DONE);
    mem_wr_en = in_run && !fifo_empty;
    mem_addr  = addr_q;
    mem_wdata = mem_wr_en ? fifo_q[rd_ptr_q] : '0;
    fifo_full = fifo_is_full;
    overflow  = overflow_q;
  end

`ifdef WB_ZERO_COUNT_EN
  assign zero_cnt = zero_cnt_q;
`endif

  // Datapath next-state logic: FIFO, address and job counters. An accepted
  // start resets the job bookkeeping. Otherwise a pop happens on each
  // transfer and a push on each accepted capture. A capture that is dropped
  // still advances captured_q, so the job always terminates.
  always_comb begin
    fifo_d     = fifo_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    occ_d      = occ_q;
    addr_d     = addr_q;
    count_d    = count_q;
    captured_d = captured_q;
    pushed_d   = pushed_q;
    written_d  = written_q;
    overflow_d = overflow_q;
`ifdef WB_ZERO_COUNT_EN
    zero_cnt_d = zero_cnt_q;
`endif
    if (start_ok) begin
      addr_d     = base_addr;
      count_d    = count;
      captured_d = '0;
      pushed_d   = '0;
      written_d  = '0;
      overflow_d = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      occ_d      = '0;
`ifdef WB_ZERO_COUNT_EN
      zero_cnt_d = '0;
`endif
    end else begin
      if (xfer) begin
        rd_ptr_d  = rd_ptr_q + PTR_W'(1);
        addr_d    = addr_q + ADDR_W'(1);
        written_d = written_q + ADDR_W'(1);
      end
      if (capture) begin
        captured_d = captured_q + ADDR_W'(1);
      end
      if (push) begin
        fifo_d[wr_ptr_q] = alu_out;
        wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        pushed_d         = pushed_q + ADDR_W'(1);
`ifdef WB_ZERO_COUNT_EN
        if (alu_zflag && (zero_cnt_q != '1)) begin
          zero_cnt_d = zero_cnt_q + ADDR_W'(1);
        end
`endif
      end
      if (drop) begin
        overflow_d = 1'b1;
      end
      case ({push, xfer})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      occ_q      <= '0;
      addr_q     <= '0;
      count_q    <= '0;
      captured_q <= '0;
      pushed_q   <= '0;
      written_q  <= '0;
      overflow_q <= 1'b0;
`ifdef WB_ZERO_COUNT_EN
      zero_cnt_q <= '0;
`endif
    end else begin
      fifo_q     <= fifo_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      captured_q <= captured_d;
      pushed_q   <= pushed_d;
      written_q  <= written_d;
      overflow_q <= overflow_d;
`ifdef WB_ZERO_COUNT_EN
      zero_cnt_q <= zero_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_writeback_buffer.sv
// tb_alu_writeback_buffer
//
// Self-checking bench for alu_writeback_buffer. It runs a table of
// single-cycle vectors, a few hand-written multi-cycle sequences, and a
// randomized phase that is checked against a queue-based reference model.
`timescale 1ns/1ps

module tb_alu_writeback_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic [7:0]  count;
  logic [15:0] alu_out;
  logic        ac_load;
  logic        alu_zflag;
  logic        mem_wr_en;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ready;
  logic        busy;
  logic        done;
  logic        fifo_full;
  logic        overflow;
`ifdef WB_ZERO_COUNT_EN
  logic [7:0]  zero_cnt;
`endif

  int compared   = 0;
  int mismatched = 0;

  alu_writeback_buffer #(.DATA_W(16), .ADDR_W(8), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_addr(base_addr),
    .count(count),
    .alu_out(alu_out),
    .ac_load(ac_load),
    .alu_zflag(alu_zflag),
    .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .busy(busy),
    .done(done),
    .fifo_full(fifo_full),
    .overflow(overflow)
`ifdef WB_ZERO_COUNT_EN
    ,
    .zero_cnt(zero_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: job phase (0 idle, 1 run, 2 done) plus a data queue
  bit          model_on = 1'b0;
  int          m_phase;
  logic [15:0] mq[$];
  logic [7:0]  m_addr;
  int          m_target;
  int          m_capt;
  int          m_written;
  int          m_drops;
  bit          m_ovf;
  int          m_zero;

  task automatic modelReset();
    m_phase   = 0;
    mq.delete();
    m_addr    = 8'h00;
    m_target  = 0;
    m_capt    = 0;
    m_written = 0;
    m_drops   = 0;
    m_ovf     = 1'b0;
    m_zero    = 0;
  endtask

  task automatic modelStep();
    bit xfer;
    bit cap;
    int pre_size;
    if (rst) begin
      modelReset();
      return;
    end
    case (m_phase)
      0: begin
        if (start) begin
          m_addr    = base_addr;
          m_target  = int'(count);
          m_capt    = 0;
          m_written = 0;
          m_drops   = 0;
          m_ovf     = 1'b0;
          m_zero    = 0;
          mq.delete();
          m_phase   = (count == 8'd0) ? 2 : 1;
        end
      end
      1: begin
        pre_size = mq.size();
        xfer     = (pre_size > 0) && mem_ready;
        cap      = ac_load && (m_capt < m_target);
        if (xfer) begin
          void'(mq.pop_front());
          m_written++;
          m_addr = m_addr + 8'd1;
        end
        if (cap) begin
          m_capt++;
          if (pre_size == DEPTH && !xfer) begin
            m_drops++;
            m_ovf = 1'b1;
          end else begin
            mq.push_back(alu_out);
            if (alu_zflag && m_zero < 255) m_zero++;
          end
        end
        if (xfer && m_written == m_target - m_drops) m_phase = 2;
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic e_wr, input logic [7:0] e_addr,
                             input logic [15:0] e_wdata, input logic e_busy, input logic e_done,
                             input logic e_full, input logic e_ovf);
    checkVal({tag, ".mem_wr_en"}, 32'(mem_wr_en), 32'(e_wr));
    checkVal({tag, ".mem_addr"},  32'(mem_addr),  32'(e_addr));
    if (e_wr) checkVal({tag, ".mem_wdata"}, 32'(mem_wdata), 32'(e_wdata));
    checkVal({tag, ".busy"},      32'(busy),      32'(e_busy));
    checkVal({tag, ".done"},      32'(done),      32'(e_done));
    checkVal({tag, ".fifo_full"}, 32'(fifo_full), 32'(e_full));
    checkVal({tag, ".overflow"},  32'(overflow),  32'(e_ovf));
  endtask

  task automatic checkModel(input string tag);
    logic        e_wr;
    logic [15:0] e_wd;
    e_wr = (m_phase == 1) && (mq.size() > 0);
    e_wd = e_wr ? mq[0] : 16'h0;
    checkOutput(tag, e_wr, m_addr, e_wd, m_phase == 1, m_phase == 2,
                mq.size() == DEPTH, m_ovf);
`ifdef WB_ZERO_COUNT_EN
    checkVal({tag, ".zero_cnt"}, 32'(zero_cnt), 32'(m_zero));
`endif
  endtask

  // Drive one cycle of inputs after a falling edge, then return at the next
  // falling edge so the outputs can be sampled away from the rising edge.
  task automatic applyStimulus(input logic st, input logic [7:0] b, input logic [7:0] c,
                               input logic ld, input logic [15:0] a, input logic z,
                               input logic rdy);
    start     = st;
    base_addr = b;
    count     = c;
    ac_load   = ld;
    alu_out   = a;
    alu_zflag = z;
    mem_ready = rdy;
    if (model_on) modelStep();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic        st;
    logic [7:0]  base;
    logic [7:0]  cnt;
    logic        ld;
    logic [15:0] alu;
    logic        e_wr;
    logic [7:0]  e_addr;
    logic [15:0] e_wdata;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t vecs[21];

  initial begin
    // job at 0x10: results 5,7,9 with memory always ready
    vecs[0]  = '{1'b1, 8'h10, 8'd3, 1'b0, 16'h0000, 1'b0, 8'h10, 16'h0000, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 8'd0, 1'b1, 16'h0005, 1'b1, 8'h10, 16'h0005, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 8'd0, 1'b1, 16'h0007, 1'b1, 8'h11, 16'h0007, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 8'd0, 1'b1, 16'h0009, 1'b1, 8'h12, 16'h0009, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 8'd0, 1'b0, 16'h0000, 1'b0, 8'h13, 16'h0000, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 8'h00, 8'd0, 1'b0, 16'h0000, 1'b0, 8'h13, 16'h0000, 1'b0, 1'b0};
    // address wrap 0xFE, 0xFF, 0x00
    vecs[6]  = '{1'b1, 8'hFE, 8'd3, 1'b0, 16'h0000, 1'b0, 8'hFE, 16'h0000, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 8'd0, 1'b1, 16'h0001, 1'b1, 8'hFE, 16'h0001, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 8'd0, 1'b1, 16'h0002, 1'b1, 8'hFF, 16'h0002, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 8'd0, 1'b1, 16'h0003, 1'b1, 8'h00, 16'h0003, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 8'd0, 1'b0, 16'h0000, 1'b0, 8'h01, 16'h0000, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 8'h00, 8'd0, 1'b0, 16'h0000, 1'b0, 8'h01, 16'h0000, 1'b0, 1'b0};
    // count==0 goes straight to done, then a start while busy is ignored
    vecs[12] = '{1'b1, 8'h40, 8'd0, 1'b0, 16'h0000, 1'b0, 8'h40, 16'h0000, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 8'h00, 8'd0, 1'b0, 16'h0000, 1'b0, 8'h40, 16'h0000, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 8'h20, 8'd2, 1'b0, 16'h0000, 1'b0, 8'h20, 16'h0000, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 8'h80, 8'd5, 1'b0, 16'h0000, 1'b0, 8'h20, 16'h0000, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 8'h00, 8'd0, 1'b1, 16'h00AA, 1'b1, 8'h20, 16'h00AA, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 8'h00, 8'd0, 1'b1, 16'h00BB, 1'b1, 8'h21, 16'h00BB, 1'b1, 1'b0};
    vecs[18] = '{1'b0, 8'h00, 8'd0, 1'b0, 16'h0000, 1'b0, 8'h22, 16'h0000, 1'b0, 1'b1};
    vecs[19] = '{1'b0, 8'h00, 8'd0, 1'b1, 16'h00CC, 1'b0, 8'h22, 16'h0000, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 8'h00, 8'd0, 1'b1, 16'h00DD, 1'b0, 8'h22, 16'h0000, 1'b0, 1'b0};

    rst = 1'b1;
    start = 1'b0; base_addr = 8'h00; count = 8'h00;
    alu_out = 16'h0; ac_load = 1'b0; alu_zflag = 1'b0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);

    checkOutput("reset", 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("reset.mem_wdata", 32'(mem_wdata), 32'h0);
`ifdef WB_ZERO_COUNT_EN
    checkVal("reset.zero_cnt", 32'(zero_cnt), 32'h0);
`endif
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00, 8'd0, 1'b0, 16'h0, 1'b0, 1'b1);

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].st, vecs[i].base, vecs[i].cnt, vecs[i].ld, vecs[i].alu, 1'b0, 1'b1);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_wr, vecs[i].e_addr, vecs[i].e_wdata,
                  vecs[i].e_busy, vecs[i].e_done, 1'b0, 1'b0);
    end

    // Memory stalled: four results fill the FIFO and the fifth is dropped
    applyStimulus(1'b1, 8'h30, 8'd5, 1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("ovf.start", 1'b0, 8'h30, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b0, 8'h00, 8'd0, 1'b1, 16'(k), 1'b0, 1'b0);
      checkOutput($sformatf("ovf.load%0d", k), 1'b1, 8'h30, 16'h0001, 1'b1, 1'b0,
                  k >= 4, k == 5);
    end
    for (int j = 0; j < 4; j++) begin
      applyStimulus(1'b0, 8'h00, 8'd0, 1'b0, 16'h0, 1'b0, 1'b1);
      if (j < 3)
        checkOutput($sformatf("ovf.drain%0d", j), 1'b1, 8'(8'h31 + j), 16'(j + 2),
                    1'b1, 1'b0, 1'b0, 1'b1);
      else
        checkOutput("ovf.drain3", 1'b0, 8'h34, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    end
    applyStimulus(1'b0, 8'h00, 8'd0, 1'b0, 16'h0, 1'b0, 1'b1);
    checkOutput("ovf.sticky", 1'b0, 8'h34, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h00, 8'd0, 1'b0, 16'h0, 1'b0, 1'b1);
    checkOutput("ovf.clear", 1'b0, 8'h00, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'd0, 1'b0, 16'h0, 1'b0, 1'b1);

    // Reset in the middle of a job while the FIFO holds two entries
    applyStimulus(1'b1, 8'h50, 8'd4, 1'b0, 16'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'd0, 1'b1, 16'h0011, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'd0, 1'b1, 16'h0022, 1'b0, 1'b0);
    checkOutput("mid.before", 1'b1, 8'h50, 16'h0011, 1'b1, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid.async", 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("mid.async.mem_wdata", 32'(mem_wdata), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 8'h00, 8'd0, 1'b1, 16'h0033, 1'b0, 1'b1);
      checkOutput($sformatf("mid.after%0d", k), 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

`ifdef WB_ZERO_COUNT_EN
    // Zero-result counting: results 0,3,0 with zflag 1,0,1
    applyStimulus(1'b1, 8'h00, 8'd3, 1'b0, 16'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 8'd0, 1'b1, 16'h0000, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'h00, 8'd0, 1'b1, 16'h0003, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 8'd0, 1'b1, 16'h0000, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'h00, 8'd0, 1'b0, 16'h0, 1'b0, 1'b1);
    checkVal("zc.count", 32'(zero_cnt), 32'd2);
    applyStimulus(1'b0, 8'h00, 8'd0, 1'b0, 16'h0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h00, 8'd0, 1'b0, 16'h0, 1'b0, 1'b1);
    checkVal("zc.clear", 32'(zero_cnt), 32'd0);
    applyStimulus(1'b0, 8'h00, 8'd0, 1'b0, 16'h0, 1'b0, 1'b1);
`endif

    // Randomized phase checked every cycle against the reference model
    rst = 1'b1;
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    model_on = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      logic        r_st;
      logic        r_ld;
      logic        r_z;
      logic        r_rdy;
      logic [15:0] r_alu;
      rst   = ($urandom_range(0, 299) == 0);
      r_st  = ($urandom_range(0, 5) == 0);
      r_ld  = ($urandom_range(0, 1) == 1);
      r_z   = ($urandom_range(0, 3) == 0);
      r_alu = r_z ? 16'h0 : 16'($urandom);
      if (((i / 64) % 2) == 0)
        r_rdy = ($urandom_range(0, 3) != 0);
      else
        r_rdy = ($urandom_range(0, 3) == 0);
      applyStimulus(r_st, 8'($urandom), 8'($urandom_range(0, 9)), r_ld, r_alu, r_z, r_rdy);
      checkModel($sformatf("rand%0d", i));
    end
    rst = 1'b0;
    model_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
